i2c_master: RTL and testbench
=============================

// Module: i2c_master
// PURPOSE
//  Single-byte I2C master controller; drives the tri-state controls of the open-drain
//  SCL/SDA wrapper that sits directly downstream (its I_SCL_T/I_SDA_T inputs).
//  Runs one transaction per command:
//   START, 7-bit address + R/W, address ACK, one data byte, data ACK/NACK, STOP.
//  Used by peripheral drivers, e.g. sensor/EEPROM register access.
// PARAMETERS
//  CLK_DIV  125  system clocks per SCL quarter-period (125 @50MHz = 100kHz); must be >= 4
// PORTS
//  I_CLK      in   1  system clock, all logic on rising edge
//  I_RESET    in   1  synchronous, active-high reset
//  I_START    in   1  command strobe; accepted only when O_BUSY=0
//  I_RW       in   1  0=write I_DATA to slave, 1=read one byte from slave
//  I_ADDR     in   7  7-bit slave address
//  I_DATA     in   8  write data byte
//  I_SCL      in   1  SCL level read back from bus (async)
//  I_SDA      in   1  SDA level read back from bus (async)
//  O_SCL_T    out  1  1=release SCL (high-Z), 0=pull SCL low
//  O_SDA_T    out  1  1=release SDA (high-Z), 0=pull SDA low
//  O_BUSY     out  1  high from command acceptance until O_DONE
//  O_DONE     out  1  one-cycle pulse at transaction end
//  O_ACK_ERR  out  1  valid with O_DONE, held until next accept; 1=slave NACKed addr or write data
//  O_RDATA    out  8  read byte, valid with O_DONE after a read, held until next read
// BEHAVIOUR
//  Reset values:
//   - O_SCL_T=1, O_SDA_T=1, O_BUSY=0, O_DONE=0, O_ACK_ERR=0, O_RDATA=0; state=IDLE.
//  Inputs and sampling:
//   - I_SCL/I_SDA pass through 2-flop synchronizers before use.
//   - I_ADDR/I_RW/I_DATA are latched on accept.
//  Timing:
//   - Quarter counter counts 0..CLK_DIV-1; each protocol bit = 4 quarters Q0..Q3.
//   - Bit quarters: Q0 SCL low, SDA driven; Q1 SCL low; Q2 SCL released; Q3 SCL released.
//   - SDA changes only at Q0 entry, never while SCL released (except START/STOP).
//  States:
//   - IDLE:
//     - both lines released.
//     - I_START=1 -> START, O_BUSY=1, O_ACK_ERR cleared.
//   - START (2 quarters): Q0 SDA/SCL released; Q1 SDA low, SCL released.
//   - ADDR (8 bits, MSB first): {addr[6:0], rw}.
//   - AACK (1 bit): SDA released; sample synced SDA on last cycle of Q2.
//     - 1 -> ACK_ERR=1, go STOP.
//     - 0 -> DATA.
//   - DATA (8 bits):
//     - write: shift out I_DATA MSB first.
//     - read: SDA released; shift in synced SDA at last cycle of Q2 of each bit.
//   - DACK (1 bit):
//     - write: sample slave ACK (NACK -> ACK_ERR=1).
//     - read: master sends NACK (SDA released).
//   - STOP (4 quarters): Q0 SCL low/SDA low; Q1 SCL released/SDA low; Q2-Q3 both released.
//   - DONE (1 cycle): O_DONE=1, O_BUSY drops to 0 next cycle, return to IDLE.
//  Clock stretching:
//   - on last cycle of any Q2 with synced SCL=0, counter holds.
//   - advance resumes the cycle after synced SCL reads 1; SDA is sampled then.
//  Latency (no stretching), accept at edge k:
//   - O_DONE high in cycle k+78*CLK_DIV on the normal path.
//   - O_DONE high in cycle k+42*CLK_DIV on address NACK.
//  Boundary conditions:
//   - I_START while busy is ignored; a command accepted in the DONE cycle is not allowed (BUSY still 1).
//   - I_RESET mid-transaction: next cycle both lines released, state=IDLE, no STOP generated, no O_DONE.
//   - Data-byte NACK on write still completes DACK and STOP; total 78 quarters.
// TESTING  (bench: open-drain bus model SCL=O_SCL_T&slave_scl, SDA=O_SDA_T&slave_sda; CLK_DIV=4)
//  1. Write addr=0x50, data=0xA5, slave ACKs both
//     -> bits at SCL rises 0xA0,0,0xA5,0; ACK_ERR=0; O_DONE 312 cycles after accept.
//  2. Read addr=0x50, slave drives 0x3C
//     -> first byte 0xA1; O_RDATA=0x3C; SDA high at 9th data SCL (NACK); STOP seen.
//  3. Write to addr=0x22, no slave ACK
//     -> ACK_ERR=1; no data bits clocked; STOP; O_DONE 168 cycles after accept.
//  4. Write 0xA5, slave holds SCL low 20 cycles during data bit 3
//     -> O_DONE delayed >=20 cycles vs test 1; slave receives 0xA5 intact.
//  5. I_RESET during address bit 4
//     -> next cycle O_SCL_T=O_SDA_T=1, BUSY=0, no DONE; a fresh write then completes as in test 1.
//  6. Second I_START pulsed while busy, plus write with data NACK
//     -> second command ignored; ACK_ERR=1; STOP still generated; 312 cycles.

Source files
------------

// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - single-byte I2C master driving open-drain SCL/SDA tri-state controls
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_START,
  input  logic       I_RW,
  input  logic [6:0] I_ADDR,
  input  logic [7:0] I_DATA,
  input  logic       I_SCL,
  input  logic       I_SDA,
  output logic       O_SCL_T,
  output logic       O_SDA_T,
  output logic       O_BUSY,
  output logic       O_DONE,
  output logic       O_ACK_ERR,
  output logic [7:0] O_RDATA
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, ADDR, AACK, DATA, DACK, STOP, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    qtr, qtr_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    addr_rw, wdata, rx_sr, rx_n, rdata_n;
  logic          ack_err, ack_err_n;
  logic          scl_n, sda_n;
  logic [1:0]    scl_ff, sda_ff;
  logic          scl_s, sda_s, rw, last, scl_phase, hold, sample;

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign rw        = addr_rw[0];
  assign last      = (cnt == CNT_LAST);
  assign scl_phase = (state == ADDR) || (state == AACK) || (state == DATA) ||
                     (state == DACK) || (state == STOP);
  // A slave stretching SCL freezes the counter at the end of Q2 until the line reads high.
  assign hold      = scl_phase && (qtr == 2'd2) && last && !scl_s;
  assign sample    = scl_phase && (qtr == 2'd2) && last && !hold;

  assign O_BUSY    = (state != IDLE);
  assign O_DONE    = (state == DONE);
  assign O_ACK_ERR = ack_err;

  function automatic logic [1:0] line_ctl(input state_t st, input logic [1:0] q,
                                          input logic [2:0] b, input logic [7:0] ab,
                                          input logic [7:0] wd, input logic rd);
    logic [1:0] r;
    r = 2'b11;
    case (st)
      START:      r = {1'b1, q == 2'd0};
      ADDR:       r = {q[1], ab[3'd7 - b]};
      AACK, DACK: r = {q[1], 1'b1};
      DATA:       r = {q[1], rd | wd[3'd7 - b]};
      STOP:       r = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b10 : 2'b11;
      default:    r = 2'b11;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    qtr_n     = qtr;
    bit_n     = bit_idx;
    rx_n      = rx_sr;
    ack_err_n = ack_err;
    rdata_n   = O_RDATA;
    case (state)
      IDLE: if (I_START) begin
        state_n   = START;
        cnt_n     = '0;
        qtr_n     = 2'd0;
        bit_n     = 3'd0;
        ack_err_n = 1'b0;
      end
      DONE: state_n = IDLE;
      default: begin
        if (!last) begin
          cnt_n = cnt + CW'(1);
        end else if (!hold) begin
          cnt_n = '0;
          qtr_n = qtr + 2'd1;
          if (state == START) begin
            if (qtr == 2'd1) begin
              state_n = ADDR;
              qtr_n   = 2'd0;
              bit_n   = 3'd0;
            end
          end else if (qtr == 2'd3) begin
            case (state)
              ADDR: begin
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = AACK;
              end
              AACK: state_n = ack_err ? STOP : DATA;
              DATA: begin
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = DACK;
              end
              DACK: begin
                state_n = STOP;
                if (rw) rdata_n = rx_sr;
              end
              STOP:    state_n = DONE;
              default: state_n = state;
            endcase
          end
        end
      end
    endcase
    if (sample) begin
      if (state == AACK && sda_s) ack_err_n = 1'b1;
      if (state == DATA && rw) rx_n = {rx_sr[6:0], sda_s};
      if (state == DACK && !rw && sda_s) ack_err_n = 1'b1;
    end
    // Line controls are registered from the next state so they switch cleanly on quarter edges.
    {scl_n, sda_n} = line_ctl(state_n, qtr_n, bit_n, addr_rw, wdata, rw);
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      qtr     <= 2'd0;
      bit_idx <= 3'd0;
      addr_rw <= 8'd0;
      wdata   <= 8'd0;
      rx_sr   <= 8'd0;
      ack_err <= 1'b0;
      O_RDATA <= 8'd0;
      O_SCL_T <= 1'b1;
      O_SDA_T <= 1'b1;
      scl_ff  <= 2'b11;
      sda_ff  <= 2'b11;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      qtr     <= qtr_n;
      bit_idx <= bit_n;
      rx_sr   <= rx_n;
      ack_err <= ack_err_n;
      O_RDATA <= rdata_n;
      O_SCL_T <= scl_n;
      O_SDA_T <= sda_n;
      scl_ff  <= {scl_ff[0], I_SCL};
      sda_ff  <= {sda_ff[0], I_SDA};
      if (state == IDLE && I_START) begin
        addr_rw <= {I_ADDR, I_RW};
        wdata   <= I_DATA;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed bench for i2c_master with an open-drain bus and slave model
module tb_i2c_master;

  localparam int CLK_DIV = 4;
  localparam int STRETCH = 24;

  logic       I_CLK = 1'b0;
  logic       I_RESET = 1'b1;
  logic       I_START = 1'b0;
  logic       I_RW = 1'b0;
  logic [6:0] I_ADDR = 7'd0;
  logic [7:0] I_DATA = 8'd0;
  logic       O_SCL_T, O_SDA_T, O_BUSY, O_DONE, O_ACK_ERR;
  logic [7:0] O_RDATA;

  logic slave_scl = 1'b1;
  logic slave_sda = 1'b1;
  wire  scl = O_SCL_T & slave_scl;
  wire  sda = O_SDA_T & slave_sda;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_START(I_START), .I_RW(I_RW),
    .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_SCL(scl), .I_SDA(sda),
    .O_SCL_T(O_SCL_T), .O_SDA_T(O_SDA_T), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
    .O_ACK_ERR(O_ACK_ERR), .O_RDATA(O_RDATA)
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // slave configuration (written by tests only)
  logic       cfg_ack_addr = 1'b1;
  logic       cfg_ack_data = 1'b1;
  logic [7:0] cfg_rd_byte = 8'h00;
  logic       cfg_stretch = 1'b0;

  // slave state (written by the slave process only)
  logic       ps = 1'b1, pd = 1'b1, s, d;
  logic       active = 1'b0, stop_seen = 1'b0, stretching = 1'b0;
  int         bc = 0, bytei = 0, rises = 0, st_cnt = 0;
  logic [7:0] sr = 8'h00, got0 = 8'h00, got1 = 8'h00;
  logic       ack0 = 1'b1, ack1 = 1'b1;

  always @(negedge I_CLK) begin
    s = scl;
    d = sda;
    if (ps && s && pd && !d) begin
      active = 1'b1; bc = 0; bytei = 0; rises = 0; stop_seen = 1'b0;
      slave_sda = 1'b1; slave_scl = 1'b1; stretching = 1'b0; st_cnt = 0;
    end else if (ps && s && !pd && d) begin
      stop_seen = 1'b1;
      active = 1'b0;
    end else if (active) begin
      if (!ps && s) begin
        rises = rises + 1;
        if (bc < 8) sr = {sr[6:0], d};
        else if (bytei == 0) ack0 = d;
        else ack1 = d;
        bc = bc + 1;
      end else if (ps && !s) begin
        if (bc == 8) begin
          if (bytei == 0) begin
            got0 = sr;
            slave_sda = cfg_ack_addr ? 1'b0 : 1'b1;
          end else begin
            got1 = sr;
            slave_sda = (!got0[0] && cfg_ack_data) ? 1'b0 : 1'b1;
          end
        end else if (bc == 9) begin
          bc = 0;
          bytei = bytei + 1;
          slave_sda = 1'b1;
          if (bytei == 1 && got0[0] && cfg_ack_addr) slave_sda = cfg_rd_byte[7];
        end else if (bc >= 1 && bytei == 1 && got0[0]) begin
          slave_sda = cfg_rd_byte[7-bc];
        end
        if (cfg_stretch && bytei == 1 && bc == 3 && !got0[0]) begin
          stretching = 1'b1;
          slave_scl = 1'b0;
          st_cnt = 0;
        end
      end
    end
    // hold SCL low for STRETCH cycles counted from the master's release
    if (stretching && O_SCL_T) begin
      st_cnt = st_cnt + 1;
      if (st_cnt == STRETCH) begin
        slave_scl = 1'b1;
        stretching = 1'b0;
      end
    end
    ps = s;
    pd = d;
  end

  int         acc;
  int         lat;
  logic       done_ok, busy1, aerr;
  logic [7:0] rd;

  task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    @(negedge I_CLK);
    I_START = 1'b1; I_RW = rw; I_ADDR = addr; I_DATA = data;
    @(posedge I_CLK);
    #1 acc = cyc;
  endtask

  task automatic run_xfer(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                          input int poke);
    issue(rw, addr, data);
    done_ok = 1'b0; busy1 = 1'b0; lat = -1; aerr = 1'bx; rd = 8'hxx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge I_CLK);
      if (i == 0) busy1 = O_BUSY;
      if (poke != 0 && i == poke) begin
        I_START = 1'b1; I_ADDR = 7'h11; I_RW = 1'b1;
      end else begin
        I_START = 1'b0;
      end
      if (O_DONE) begin
        done_ok = 1'b1; lat = cyc - acc; aerr = O_ACK_ERR; rd = O_RDATA;
        break;
      end
    end
    I_START = 1'b0;
    checks++;
    if (done_ok !== 1'b1) begin
      errors++; $display("FAIL done_timeout: got %0b want 1", done_ok);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge I_CLK);
    checks += 6;
    if (O_SCL_T !== 1'b1) begin errors++; $display("FAIL rst_scl_t: got %b want 1", O_SCL_T); end
    if (O_SDA_T !== 1'b1) begin errors++; $display("FAIL rst_sda_t: got %b want 1", O_SDA_T); end
    if (O_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", O_BUSY); end
    if (O_DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", O_DONE); end
    if (O_ACK_ERR !== 1'b0) begin errors++; $display("FAIL rst_ack_err: got %b want 0", O_ACK_ERR); end
    if (O_RDATA !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h want 00", O_RDATA); end
    I_RESET = 1'b0;
    repeat (2) @(negedge I_CLK);
  endtask

  task automatic test_write;
    cfg_ack_addr = 1'b1; cfg_ack_data = 1'b1; cfg_stretch = 1'b0;
    run_xfer(1'b0, 7'h50, 8'hA5, 0);
    @(negedge I_CLK);
    checks += 10;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy1); end
    if (lat !== 312) begin errors++; $display("FAIL wr_latency: got %0d want 312", lat); end
    if (got0 !== 8'hA0) begin errors++; $display("FAIL wr_addr_byte: got %h want a0", got0); end
    if (ack0 !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: got %b want 0", ack0); end
    if (got1 !== 8'hA5) begin errors++; $display("FAIL wr_data_byte: got %h want a5", got1); end
    if (ack1 !== 1'b0) begin errors++; $display("FAIL wr_data_ack: got %b want 0", ack1); end
    if (aerr !== 1'b0) begin errors++; $display("FAIL wr_ack_err: got %b want 0", aerr); end
    if (rises !== 19) begin errors++; $display("FAIL wr_scl_rises: got %0d want 19", rises); end
    if (stop_seen !== 1'b1) begin errors++; $display("FAIL wr_stop: got %b want 1", stop_seen); end
    if (O_BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_after: got %b want 0", O_BUSY); end
  endtask

  task automatic test_read;
    cfg_ack_addr = 1'b1; cfg_rd_byte = 8'h3C;
    run_xfer(1'b1, 7'h50, 8'h00, 0);
    repeat (2) @(negedge I_CLK);
    checks += 6;
    if (got0 !== 8'hA1) begin errors++; $display("FAIL rd_addr_byte: got %h want a1", got0); end
    if (rd !== 8'h3C) begin errors++; $display("FAIL rd_rdata: got %h want 3c", rd); end
    if (ack1 !== 1'b1) begin errors++; $display("FAIL rd_master_nack: got %b want 1", ack1); end
    if (stop_seen !== 1'b1) begin errors++; $display("FAIL rd_stop: got %b want 1", stop_seen); end
    if (aerr !== 1'b0) begin errors++; $display("FAIL rd_ack_err: got %b want 0", aerr); end
    if (lat !== 312) begin errors++; $display("FAIL rd_latency: got %0d want 312", lat); end
  endtask

  task automatic test_addr_nack;
    cfg_ack_addr = 1'b0;
    run_xfer(1'b0, 7'h22, 8'h5A, 0);
    repeat (2) @(negedge I_CLK);
    cfg_ack_addr = 1'b1;
    checks += 6;
    if (aerr !== 1'b1) begin errors++; $display("FAIL nack_ack_err: got %b want 1", aerr); end
    if (got0 !== 8'h44) begin errors++; $display("FAIL nack_addr_byte: got %h want 44", got0); end
    if (rises !== 10) begin errors++; $display("FAIL nack_scl_rises: got %0d want 10", rises); end
    if (stop_seen !== 1'b1) begin errors++; $display("FAIL nack_stop: got %b want 1", stop_seen); end
    if (lat !== 168) begin errors++; $display("FAIL nack_latency: got %0d want 168", lat); end
    if (rd !== 8'h3C) begin errors++; $display("FAIL nack_rdata_held: got %h want 3c", rd); end
  endtask

  task automatic test_stretch;
    cfg_stretch = 1'b1;
    run_xfer(1'b0, 7'h50, 8'hA5, 0);
    repeat (2) @(negedge I_CLK);
    cfg_stretch = 1'b0;
    checks += 3;
    if (got1 !== 8'hA5) begin errors++; $display("FAIL str_data_byte: got %h want a5", got1); end
    if (lat !== 312 + STRETCH - 2) begin
      errors++; $display("FAIL str_latency: got %0d want %0d", lat, 312 + STRETCH - 2);
    end
    if (aerr !== 1'b0) begin errors++; $display("FAIL str_ack_err: got %b want 0", aerr); end
  endtask

  task automatic test_reset_mid;
    int   n_done;
    logic hit;
    issue(1'b0, 7'h50, 8'hA5);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge I_CLK);
      I_START = 1'b0;
      if (active && bytei == 0 && bc == 4) begin hit = 1'b1; break; end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL mid_addr_bit4_reached: got %b want 1", hit); end
    I_RESET = 1'b1;
    @(negedge I_CLK);
    I_RESET = 1'b0;
    checks += 4;
    if (O_SCL_T !== 1'b1) begin errors++; $display("FAIL mid_scl_t: got %b want 1", O_SCL_T); end
    if (O_SDA_T !== 1'b1) begin errors++; $display("FAIL mid_sda_t: got %b want 1", O_SDA_T); end
    if (O_BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", O_BUSY); end
    if (O_DONE !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", O_DONE); end
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge I_CLK);
      if (O_DONE) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", n_done); end
    run_xfer(1'b0, 7'h50, 8'hA5, 0);
    repeat (2) @(negedge I_CLK);
    checks += 3;
    if (lat !== 312) begin errors++; $display("FAIL mid_re_latency: got %0d want 312", lat); end
    if (got1 !== 8'hA5) begin errors++; $display("FAIL mid_re_data: got %h want a5", got1); end
    if (aerr !== 1'b0) begin errors++; $display("FAIL mid_re_ack_err: got %b want 0", aerr); end
  endtask

  task automatic test_back_to_back;
    int n_busy;
    cfg_ack_data = 1'b0;
    run_xfer(1'b0, 7'h50, 8'h3C, 50);
    repeat (2) @(negedge I_CLK);
    cfg_ack_data = 1'b1;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge I_CLK);
      if (O_BUSY) n_busy++;
    end
    checks += 7;
    if (got0 !== 8'hA0) begin errors++; $display("FAIL b2b_addr_byte: got %h want a0", got0); end
    if (got1 !== 8'h3C) begin errors++; $display("FAIL b2b_data_byte: got %h want 3c", got1); end
    if (aerr !== 1'b1) begin errors++; $display("FAIL b2b_ack_err: got %b want 1", aerr); end
    if (stop_seen !== 1'b1) begin errors++; $display("FAIL b2b_stop: got %b want 1", stop_seen); end
    if (rises !== 19) begin errors++; $display("FAIL b2b_scl_rises: got %0d want 19", rises); end
    if (lat !== 312) begin errors++; $display("FAIL b2b_latency: got %0d want 312", lat); end
    if (n_busy !== 0) begin errors++; $display("FAIL b2b_ignored_cmd: got %0d want 0", n_busy); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_addr_nack;
    test_stretch;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
